unidade_busca: RTL and testbench

UNIDADE_BUSCA -- requirements
Module: unidade_busca

---
 rtl/unidade_busca_pkg.sv | 16 +
 rtl/unidade_busca_if.sv | 31 +++
 rtl/unidade_busca_fila_instrucao.sv | 79 +++++++
 rtl/unidade_busca.sv | 115 +++++++++++
 tb/tb_unidade_busca.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default word width and instruction buffer depth.
package unidade_busca_pkg;

    localparam int unsigned LARGURA      = 16;
    localparam int unsigned PROFUNDIDADE = 2;
    localparam int unsigned LARGURA_CONT = 2;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        REQUISITA  = 2'd1,
        INCREMENTA = 2'd2,
        DESCARTA   = 2'd3
    } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Instruction-memory read channel between the fetch unit (master) and the
// instruction memory (slave).
//   memReq      : read request, held until memAck
//   memEndereco : read address, stable while memReq=1
//   memAck      : completion strobe, memDado valid in the same cycle
//   memDado     : instruction word returned by memory
interface unidade_busca_if #(
    parameter int unsigned LARGURA = unidade_busca_pkg::LARGURA
);
    import unidade_busca_pkg::*;

    logic               memReq;
    logic [LARGURA-1:0] memEndereco;
    logic               memAck;
    logic [LARGURA-1:0] memDado;

    modport master (
        output memReq,
        output memEndereco,
        input  memAck,
        input  memDado
    );

    modport slave (
        input  memReq,
        input  memEndereco,
        output memAck,
        output memDado
    );

endinterface

// File: rtl/unidade_busca_fila_instrucao.sv
// Two-entry instruction FIFO holding {instruction, address} pairs.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write dado_i at the tail
//   pop_i      : drop the head (ignored when empty)
//   flush_i    : empty the queue; has priority over push/pop
//   dado_i     : entry to write
//   cabeca_o   : head entry; keeps its last value while empty
//   cont_o     : number of valid entries
module fila_instrucao #(
    parameter int unsigned LARGURA_ENTRADA = 32,
    parameter int unsigned PROFUNDIDADE    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [LARGURA_ENTRADA-1:0] dado_i,
    output logic [LARGURA_ENTRADA-1:0] cabeca_o,
    output logic [1:0]                 cont_o
);
    import unidade_busca_pkg::*;

    logic [LARGURA_ENTRADA-1:0] ent0_q, ent0_d;
    logic [LARGURA_ENTRADA-1:0] ent1_q, ent1_d;
    logic [LARGURA_CONT-1:0]    cont_q, cont_d;
    logic                       pop_ok;
    logic                       cheia;

    assign pop_ok = pop_i && (cont_q != '0);
    assign cheia  = (cont_q >= LARGURA_CONT'(PROFUNDIDADE));

    // Next-state: the head only shifts when a second entry exists, so an
    // emptied queue keeps presenting the last popped entry.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cont_d = cont_q;
        if (flush_i) begin
            cont_d = '0;
        end else if (push_i && pop_ok) begin
            if (cont_q == LARGURA_CONT'(1)) begin
                ent0_d = dado_i;
            end else begin
                ent0_d = ent1_q;
                ent1_d = dado_i;
            end
        end else if (push_i && !cheia) begin
            if (cont_q == '0) begin
                ent0_d = dado_i;
            end else begin
                ent1_d = dado_i;
            end
            cont_d = cont_q + LARGURA_CONT'(1);
        end else if (pop_ok) begin
            if (cont_q == LARGURA_CONT'(2)) begin
                ent0_d = ent1_q;
            end
            cont_d = cont_q - LARGURA_CONT'(1);
        end
    end

    // Storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cont_q <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cont_q <= cont_d;
        end
    end

    assign cabeca_o = ent0_q;
    assign cont_o   = cont_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: issues one instruction-memory read at a time from
// the current PC, pulses incrementaPC after each accepted word, and queues
// fetched words in a 2-entry buffer for the decoder. desvio flushes the
// buffer and turns an in-flight read into a discarded one.
//   Clock, Resetn : clock, async active-low reset
//   habilita      : fetch enable (gates new requests only)
//   pcAtual       : current PC value
//   desvio        : PC written with a jump target this cycle
//   incrementaPC  : one-cycle pulse to advance the PC
//   mem           : instruction-memory read channel (master side)
//   instrucao     : head-of-buffer instruction
//   instrEndereco : address the head instruction was fetched from
//   instrValida   : buffer non-empty
//   instrPronta   : decoder accepts the head this cycle
module unidade_busca #(
    parameter int unsigned LARGURA      = unidade_busca_pkg::LARGURA,
    parameter int unsigned PROFUNDIDADE = unidade_busca_pkg::PROFUNDIDADE
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               habilita,
    input  logic [LARGURA-1:0] pcAtual,
    input  logic               desvio,
    output logic               incrementaPC,
    unidade_busca_if.master    mem,
    output logic [LARGURA-1:0] instrucao,
    output logic [LARGURA-1:0] instrEndereco,
    output logic               instrValida,
    input  logic               instrPronta
);
    import unidade_busca_pkg::*;

    estado_t                 estado_q, estado_d;
    logic [LARGURA-1:0]      end_reg_q, end_reg_d;
    logic                    push_c;
    logic                    pop_c;
    logic [LARGURA_CONT-1:0] fila_cont;
    logic [2*LARGURA-1:0]    fila_cabeca;

    // Next-state and request/push decode
    always_comb begin
        estado_d  = estado_q;
        end_reg_d = end_reg_q;
        push_c    = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (habilita && !desvio &&
                    (fila_cont < LARGURA_CONT'(PROFUNDIDADE))) begin
                    estado_d  = REQUISITA;
                    end_reg_d = pcAtual;
                end
            end
            REQUISITA: begin
                if (mem.memAck) begin
                    if (desvio) begin
                        estado_d = OCIOSO;
                    end else begin
                        push_c   = 1'b1;
                        estado_d = INCREMENTA;
                    end
                end else if (desvio) begin
                    estado_d = DESCARTA;
                end
            end
            INCREMENTA: begin
                estado_d = OCIOSO;
            end
            DESCARTA: begin
                // Wait out the stale read; its data is dropped.
                if (mem.memAck) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and request address registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado_q  <= OCIOSO;
            end_reg_q <= '0;
        end else begin
            estado_q  <= estado_d;
            end_reg_q <= end_reg_d;
        end
    end

    assign mem.memReq      = (estado_q == REQUISITA) || (estado_q == DESCARTA);
    assign mem.memEndereco = end_reg_q;
    // A jump in the same cycle overrides the increment at the PC register.
    assign incrementaPC    = (estado_q == INCREMENTA) && !desvio;
    assign pop_c           = instrValida && instrPronta;

    fila_instrucao #(
        .LARGURA_ENTRADA (2*LARGURA),
        .PROFUNDIDADE    (PROFUNDIDADE)
    ) u_fila (
        .clk      (Clock),
        .rst_n    (Resetn),
        .push_i   (push_c),
        .pop_i    (pop_c),
        .flush_i  (desvio),
        .dado_i   ({mem.memDado, end_reg_q}),
        .cabeca_o (fila_cabeca),
        .cont_o   (fila_cont)
    );

    assign instrucao     = fila_cabeca[2*LARGURA-1:LARGURA];
    assign instrEndereco = fila_cabeca[LARGURA-1:0];
    assign instrValida   = (fila_cont != '0);

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: PC register model, instruction
// memory responder, and a scoreboard of expected {instruction, address}
// pairs checked as the decoder side pops them.
module tb_unidade_busca;
    import unidade_busca_pkg::*;

    localparam int unsigned L = 16;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         habilita;
    logic [L-1:0] pcAtual;
    logic         desvio;
    logic         incrementaPC;
    logic [L-1:0] instrucao;
    logic [L-1:0] instrEndereco;
    logic         instrValida;
    logic         instrPronta;

    unidade_busca_if #(.LARGURA(L)) mem_if ();

    unidade_busca #(.LARGURA(L), .PROFUNDIDADE(2)) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .habilita      (habilita),
        .pcAtual       (pcAtual),
        .desvio        (desvio),
        .incrementaPC  (incrementaPC),
        .mem           (mem_if),
        .instrucao     (instrucao),
        .instrEndereco (instrEndereco),
        .instrValida   (instrValida),
        .instrPronta   (instrPronta)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [2*L-1:0] sb [$];
    logic [L-1:0]   memoria [logic [L-1:0]];
    logic [L-1:0]   alvo = '0;
    bit             mem_auto = 1'b0;
    bit             ack_manual = 1'b0;
    logic [L-1:0]   dado_manual = '0;
    bit             pronta_cfg = 1'b0;
    bit             pronta_no_ack = 1'b0;
    int             atraso = 1;
    int             n_acks = 0;
    int             n_inc = 0;
    int             n_pops = 0;

    function automatic logic [L-1:0] ler(input logic [L-1:0] a);
        if (memoria.exists(a)) return memoria[a];
        return a ^ 16'hC3C3;
    endfunction

    // PC register: jump target has priority over increment
    initial begin : modelo_pc
        logic         inc_s;
        logic         des_s;
        logic [L-1:0] alvo_s;
        pcAtual = '0;
        forever begin
            @(negedge Clock);
            inc_s  = incrementaPC;
            des_s  = desvio;
            alvo_s = alvo;
            if (incrementaPC === 1'b1) n_inc++;
            @(posedge Clock);
            #1;
            if (Resetn) begin
                if (des_s) pcAtual = alvo_s;
                else if (inc_s) pcAtual = pcAtual + 16'd1;
            end
        end
    end

    // Instruction memory and decoder-ready driver
    initial begin : resposta_memoria
        bit           ack_agora;
        bit           descartar;
        int           espera;
        logic [L-1:0] dado;
        logic [L-1:0] dado_esp;
        logic [L-1:0] end_esp;
        mem_if.memAck  = 1'b0;
        mem_if.memDado = '0;
        instrPronta    = 1'b0;
        descartar      = 1'b0;
        espera         = 0;
        dado           = '0;
        dado_esp       = '0;
        end_esp        = '0;
        forever begin
            @(posedge Clock);
            #3;
            ack_agora = 1'b0;
            if (!Resetn) begin
                espera    = 0;
                descartar = 1'b0;
            end else if (mem_if.memAck) begin
                espera = 0;
            end else if (mem_if.memReq) begin
                espera++;
                if (espera == 1) begin
                    end_esp = pcAtual;
                    checks++;
                    if (mem_if.memEndereco !== pcAtual) begin
                        errors++;
                        $display("FAIL endereco_req: obtido %h esperado %h", mem_if.memEndereco, pcAtual);
                    end
                end
                if (ack_manual) begin
                    ack_agora = 1'b1;
                    dado      = dado_manual;
                    dado_esp  = dado_manual;
                end else if (mem_auto && espera >= atraso) begin
                    ack_agora = 1'b1;
                    dado      = ler(mem_if.memEndereco);
                    dado_esp  = ler(end_esp);
                end
            end
            mem_if.memAck = ack_agora;
            if (ack_agora) begin
                mem_if.memDado = dado;
                n_acks++;
                if (!desvio && !descartar) sb.push_back({dado_esp, end_esp});
                descartar = 1'b0;
            end else if (desvio && mem_if.memReq && Resetn) begin
                descartar = 1'b1;
            end
            instrPronta = pronta_no_ack ? ack_agora : pronta_cfg;
        end
    end

    // Decoder side: every accepted head must match the scoreboard front
    initial begin : consumidor
        logic [2*L-1:0] esp;
        forever begin
            @(posedge Clock);
            #4;
            if (Resetn && !desvio && instrValida && instrPronta) begin
                checks++;
                n_pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL consumo: obtido %h/%h sem valor esperado", instrucao, instrEndereco);
                end else begin
                    esp = sb.pop_front();
                    if ({instrucao, instrEndereco} !== esp) begin
                        errors++;
                        $display("FAIL ordem: obtido %h/%h esperado %h/%h",
                                 instrucao, instrEndereco, esp[2*L-1:L], esp[L-1:0]);
                    end
                end
            end
        end
    end

    initial begin : vigia
        #100000;
        $display("FAIL watchdog: obtido timeout esperado fim");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic pulso_desvio(input logic [L-1:0] a);
        alvo   = a;
        desvio = 1'b1;
        sb.delete();
        tick();
        desvio = 1'b0;
    endtask

    task automatic espera_memreq(input string nome);
        int i;
        i = 0;
        while (mem_if.memReq !== 1'b1 && i < 50) begin
            tick();
            i++;
        end
        checks++;
        if (mem_if.memReq !== 1'b1) begin
            errors++;
            $display("FAIL %s_memreq: obtido %b esperado 1", nome, mem_if.memReq);
        end
    endtask

    task automatic test_reset();
        Resetn   = 1'b0;
        habilita = 1'b0;
        desvio   = 1'b0;
        tick();
        tick();
        checks += 6;
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: obtido %b esperado 0", mem_if.memReq); end
        if (mem_if.memEndereco !== 16'h0000) begin errors++; $display("FAIL reset_memEndereco: obtido %h esperado 0000", mem_if.memEndereco); end
        if (incrementaPC !== 1'b0) begin errors++; $display("FAIL reset_incrementaPC: obtido %b esperado 0", incrementaPC); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL reset_instrValida: obtido %b esperado 0", instrValida); end
        if (instrucao !== 16'h0000) begin errors++; $display("FAIL reset_instrucao: obtido %h esperado 0000", instrucao); end
        if (instrEndereco !== 16'h0000) begin errors++; $display("FAIL reset_instrEndereco: obtido %h esperado 0000", instrEndereco); end
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_busca_basica();
        int n0, p0;
        memoria[16'h0010] = 16'hA5A5;
        mem_auto   = 1'b1;
        atraso     = 3;
        pronta_cfg = 1'b0;
        pulso_desvio(16'h0010);
        n0 = n_inc;
        p0 = n_pops;
        habilita = 1'b1;
        espera_memreq("basica");
        checks++;
        if (mem_if.memEndereco !== 16'h0010) begin errors++; $display("FAIL basica_endereco: obtido %h esperado 0010", mem_if.memEndereco); end
        habilita = 1'b0;
        repeat (8) tick();
        checks += 5;
        if (n_inc - n0 != 1) begin errors++; $display("FAIL basica_incrementos: obtido %0d esperado 1", n_inc - n0); end
        if (instrValida !== 1'b1) begin errors++; $display("FAIL basica_valida: obtido %b esperado 1", instrValida); end
        if (instrucao !== 16'hA5A5) begin errors++; $display("FAIL basica_instrucao: obtido %h esperado a5a5", instrucao); end
        if (instrEndereco !== 16'h0010) begin errors++; $display("FAIL basica_instrEndereco: obtido %h esperado 0010", instrEndereco); end
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL basica_ocioso: obtido %b esperado 0", mem_if.memReq); end
        pronta_cfg = 1'b1;
        repeat (3) tick();
        checks += 2;
        if (instrValida !== 1'b0) begin errors++; $display("FAIL basica_vazia: obtido %b esperado 0", instrValida); end
        if (n_pops - p0 != 1) begin errors++; $display("FAIL basica_pops: obtido %0d esperado 1", n_pops - p0); end
    endtask

    task automatic test_contrapressao();
        int n0, a0, p0, i;
        mem_auto   = 1'b1;
        atraso     = 1;
        pronta_cfg = 1'b0;
        pulso_desvio(16'h0020);
        n0 = n_inc;
        a0 = n_acks;
        p0 = n_pops;
        habilita = 1'b1;
        repeat (30) tick();
        checks += 4;
        if (n_acks - a0 != 2) begin errors++; $display("FAIL contra_buscas: obtido %0d esperado 2", n_acks - a0); end
        if (n_inc - n0 != 2) begin errors++; $display("FAIL contra_incrementos: obtido %0d esperado 2", n_inc - n0); end
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL contra_memReq: obtido %b esperado 0", mem_if.memReq); end
        if (instrValida !== 1'b1) begin errors++; $display("FAIL contra_valida: obtido %b esperado 1", instrValida); end
        pronta_cfg = 1'b1;
        i = 0;
        while (n_acks - a0 < 3 && i < 30) begin
            tick();
            i++;
        end
        habilita = 1'b0;
        checks++;
        if (n_acks - a0 != 3) begin errors++; $display("FAIL contra_terceira: obtido %0d esperado 3", n_acks - a0); end
        repeat (10) tick();
        checks += 2;
        if (n_pops - p0 != 3) begin errors++; $display("FAIL contra_pops: obtido %0d esperado 3", n_pops - p0); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL contra_vazia: obtido %b esperado 0", instrValida); end
    endtask

    task automatic test_descarte_em_voo();
        int n0, p0;
        logic [L-1:0] pc_antes;
        mem_auto   = 1'b0;
        pronta_cfg = 1'b1;
        pc_antes   = pcAtual;
        n0 = n_inc;
        habilita = 1'b1;
        espera_memreq("descarte");
        habilita = 1'b0;
        tick();
        pulso_desvio(16'h0080);
        tick();
        tick();
        checks += 2;
        if (mem_if.memReq !== 1'b1) begin errors++; $display("FAIL descarte_memReq: obtido %b esperado 1", mem_if.memReq); end
        if (mem_if.memEndereco !== pc_antes) begin errors++; $display("FAIL descarte_estavel: obtido %h esperado %h", mem_if.memEndereco, pc_antes); end
        ack_manual  = 1'b1;
        dado_manual = 16'h1234;
        tick();
        ack_manual = 1'b0;
        repeat (4) tick();
        checks += 3;
        if (n_inc - n0 != 0) begin errors++; $display("FAIL descarte_incrementos: obtido %0d esperado 0", n_inc - n0); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL descarte_vazia: obtido %b esperado 0", instrValida); end
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL descarte_ocioso: obtido %b esperado 0", mem_if.memReq); end
        mem_auto = 1'b1;
        atraso   = 2;
        p0 = n_pops;
        habilita = 1'b1;
        espera_memreq("descarte_nova");
        checks++;
        if (mem_if.memEndereco !== 16'h0080) begin errors++; $display("FAIL descarte_novo_endereco: obtido %h esperado 0080", mem_if.memEndereco); end
        habilita = 1'b0;
        repeat (8) tick();
        checks++;
        if (n_pops - p0 != 1) begin errors++; $display("FAIL descarte_pops: obtido %0d esperado 1", n_pops - p0); end
    endtask

    task automatic test_desvio_com_ack();
        int n0;
        mem_auto   = 1'b0;
        pronta_cfg = 1'b1;
        habilita   = 1'b1;
        espera_memreq("simult");
        habilita = 1'b0;
        tick();
        n0          = n_inc;
        alvo        = 16'h0100;
        desvio      = 1'b1;
        sb.delete();
        ack_manual  = 1'b1;
        dado_manual = 16'hBEEF;
        tick();
        desvio     = 1'b0;
        ack_manual = 1'b0;
        checks += 2;
        if (dut.estado_q !== OCIOSO) begin errors++; $display("FAIL simult_estado: obtido %0d esperado %0d", dut.estado_q, OCIOSO); end
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL simult_memReq: obtido %b esperado 0", mem_if.memReq); end
        repeat (3) tick();
        checks += 2;
        if (n_inc - n0 != 0) begin errors++; $display("FAIL simult_incrementos: obtido %0d esperado 0", n_inc - n0); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL simult_vazia: obtido %b esperado 0", instrValida); end
    endtask

    task automatic test_reset_assincrono();
        int i;
        mem_auto   = 1'b1;
        atraso     = 6;
        pronta_cfg = 1'b0;
        habilita   = 1'b1;
        i = 0;
        while (!(instrValida === 1'b1 && mem_if.memReq === 1'b1) && i < 60) begin
            tick();
            i++;
        end
        checks++;
        if (!(instrValida === 1'b1 && mem_if.memReq === 1'b1)) begin
            errors++;
            $display("FAIL rst_preparo: obtido %b%b esperado 11", instrValida, mem_if.memReq);
        end
        #2;
        Resetn   = 1'b0;
        habilita = 1'b0;
        sb.delete();
        #1;
        checks += 4;
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL rst_async_memReq: obtido %b esperado 0", mem_if.memReq); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL rst_async_valida: obtido %b esperado 0", instrValida); end
        if (instrucao !== 16'h0000) begin errors++; $display("FAIL rst_async_instrucao: obtido %h esperado 0000", instrucao); end
        if (mem_if.memEndereco !== 16'h0000) begin errors++; $display("FAIL rst_async_endereco: obtido %h esperado 0000", mem_if.memEndereco); end
        tick();
        tick();
        Resetn = 1'b1;
        repeat (3) tick();
        checks++;
        if (mem_if.memReq !== 1'b0) begin errors++; $display("FAIL rst_pos_memReq: obtido %b esperado 0", mem_if.memReq); end
    endtask

    task automatic test_back_to_back();
        int a0, p0, i;
        mem_auto      = 1'b1;
        atraso        = 1;
        pronta_cfg    = 1'b0;
        pulso_desvio(16'h0200);
        pronta_no_ack = 1'b1;
        a0 = n_acks;
        p0 = n_pops;
        habilita = 1'b1;
        i = 0;
        while (n_acks - a0 < 9 && i < 200) begin
            tick();
            i++;
            if (mem_if.memAck === 1'b1) begin
                checks++;
                if (dut.fila_cont !== 2'd1) begin
                    errors++;
                    $display("FAIL b2b_cont: obtido %0d esperado 1", dut.fila_cont);
                end
            end
        end
        habilita = 1'b0;
        checks++;
        if (n_acks - a0 != 9) begin errors++; $display("FAIL b2b_buscas: obtido %0d esperado 9", n_acks - a0); end
        tick();
        pronta_no_ack = 1'b0;
        pronta_cfg    = 1'b1;
        repeat (6) tick();
        checks += 2;
        if (n_pops - p0 != 9) begin errors++; $display("FAIL b2b_pops: obtido %0d esperado 9", n_pops - p0); end
        if (instrValida !== 1'b0) begin errors++; $display("FAIL b2b_vazia: obtido %b esperado 0", instrValida); end
    endtask

    initial begin : principal
        test_reset();
        test_busca_basica();
        test_contrapressao();
        test_descarte_em_voo();
        test_desvio_com_ack();
        test_reset_assincrono();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sobra_scoreboard: obtido %0d esperado 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
